divider_unit: RTL
=================

// Module: divider_unit
// PURPOSE
//  Iterative radix-2 restoring divider for DIV/DIVU, beside the EX stage of the cpu pipeline.
//  EX launches an operation and stalls the pipeline while busy; quotient/remainder go to HI/LO write-back.
//  Shift/ALU ops are unaffected: they bypass this unit and complete in EX in one cycle.
// PARAMETERS
//  WIDTH      32   operand/result width in bits
//  CNT_WIDTH  6    iteration counter width; must hold WIDTH
// PORTS
//  clock       in   1      single clock, rising edge
//  reset       in   1      asynchronous, active-low reset
//  start       in   1      launch request, sampled in IDLE/DONE only
//  signed_div  in   1      1 = DIV (two's complement), 0 = DIVU
//  operand_a   in   WIDTH  dividend (rs)
//  operand_b   in   WIDTH  divisor (rt)
//  cancel      in   1      pipeline flush; abort the operation in flight
//  busy        out  1      high from the cycle after start until done; EX stalls on it
//  done        out  1      one-cycle pulse; results valid
//  result_lo   out  WIDTH  quotient, to LO
//  result_hi   out  WIDTH  remainder, to HI
// BEHAVIOUR
//  - Reset (async, reset==0): state=IDLE, busy=0, done=0, result_lo=0, result_hi=0, counter=0.
//  - States: IDLE, ZERO, RUN, DONE.
//    IDLE/DONE + start: operand_b==0 -> ZERO, else -> RUN. Operands latched on the start edge.
//    ZERO -> DONE after 1 cycle. RUN -> DONE when counter hits WIDTH. DONE -> IDLE when start is absent.
//  - Latency: start in cycle 0; RUN iterates cycles 1..WIDTH; done=1 in cycle WIDTH+1 (33 for WIDTH=32).
//  - busy=1 in ZERO and RUN only; done=1 only in DONE; start is ignored while busy.
//  - Signed: divide magnitudes. Quotient is negated if operand signs differ. Remainder takes the dividend's sign.
//  - 0x80000000 / 0xFFFFFFFF (signed): lo=0x80000000, hi=0; no trap.
//  - Divide by zero: lo={WIDTH{1'b1}}, hi=operand_a; this is decided behaviour, not an X.
//  - cancel (any state): next state IDLE, busy=0, no done pulse, result_* keep old values.
//  - cancel and start in the same cycle: cancel wins and start is dropped.
//  - result_lo/result_hi update only on entry to DONE and hold until the next completion.
//  - Reset asserted mid-operation clears everything immediately; no done pulse.
// CONFIGURATION
//  DIVIDER_EARLY_OUT_EN defined: in IDLE/DONE + start, if |a| < |b| (and b!=0), go to ZERO-like 1-cycle path.
//    Result: lo=0, hi=operand_a; done in cycle 2.
//  Undefined: every nonzero divisor takes the full WIDTH iterations; results are identical.
// STRUCTURE
//  - divider_pkg: WIDTH default, state enum (IDLE/ZERO/RUN/DONE), DIV_BY_ZERO_LO constant.
//  - div_step: combinational sub-module for one restoring iteration.
//    In: partial remainder, dividend bit, divisor. Out: next remainder, quotient bit.
//  - divider_unit holds the FSM, counter, sign fix-up and result registers.
// TESTING
//  - DIVU 100/7 -> done at cycle 33, lo=0x0000000E, hi=0x00000002; busy high cycles 1..32.
//  - DIV 0xFFFFFFF9(-7)/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU of same -> lo=0x7FFFFFFC, hi=1.
//  - DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0; DIV 0x80000000/2 -> lo=0xC0000000, hi=0.
//  - DIVU 5/0 -> done at cycle 2, lo=0xFFFFFFFF, hi=5.
//  - Start 100/7, cancel at cycle 10 -> busy=0 at 11, no done, results unchanged.
//    Then start 9/3 -> lo=3, hi=0 at +33. Repeat with start+cancel together -> no launch.
//  - Early-out 3/10: with DIVIDER_EARLY_OUT_EN done at cycle 2, without it at cycle 33; both lo=0, hi=3.
//  - Reset pulse at cycle 15 of a run -> all outputs 0 immediately, state IDLE.

Source files
------------

// File: rtl/divider_pkg.sv
// Shared types and constants for the iterative restoring divider.
package divider_pkg;

  localparam int unsigned DIV_WIDTH     = 32;
  localparam int unsigned DIV_CNT_WIDTH = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ZERO = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } div_state_t;

  // Quotient reported for a zero divisor (all ones at any width).
  localparam logic [DIV_WIDTH-1:0] DIV_BY_ZERO_LO = '1;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring iteration: shift in a dividend bit, trial-subtract the divisor.
module div_step
  import divider_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             dvd_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next_c,
  output logic             q_bit_c
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // rem < divisor holds, so the trial difference is either < divisor or negative.
  assign shifted    = {rem, dvd_bit};
  assign diff       = shifted - {1'b0, divisor};
  assign q_bit_c    = ~diff[WIDTH];
  assign rem_next_c = q_bit_c ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/divider_unit.sv
// DIV/DIVU unit beside EX: FSM, iteration counter, sign fix-up and HI/LO result registers.
// Optional: define DIVIDER_EARLY_OUT_EN to finish |a| < |b| in one cycle.
module divider_unit
  import divider_pkg::*;
#(
  parameter int unsigned WIDTH     = DIV_WIDTH,
  parameter int unsigned CNT_WIDTH = DIV_CNT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_div,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi
);

  div_state_t           state_q, state_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]     dvd_q, dvd_d;
  logic [WIDTH-1:0]     rem_q, rem_d;
  logic [WIDTH-1:0]     dvs_q, dvs_d;
  logic                 quot_neg_q, quot_neg_d;
  logic                 rem_neg_q, rem_neg_d;
  logic                 dbz_q, dbz_d;

  logic                 a_neg, b_neg;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic                 early_c;
  logic [WIDTH-1:0]     step_rem;
  logic                 step_q;
  logic [WIDTH-1:0]     quot_c;

  assign a_neg = signed_div & operand_a[WIDTH-1];
  assign b_neg = signed_div & operand_b[WIDTH-1];
  assign a_mag = a_neg ? (~operand_a + WIDTH'(1)) : operand_a;
  assign b_mag = b_neg ? (~operand_b + WIDTH'(1)) : operand_b;

`ifdef DIVIDER_EARLY_OUT_EN
  assign early_c = (operand_b != '0) && (a_mag < b_mag);
`else
  assign early_c = 1'b0;
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem        (rem_q),
    .dvd_bit    (dvd_q[WIDTH-1]),
    .divisor    (dvs_q),
    .rem_next_c (step_rem),
    .q_bit_c    (step_q)
  );

  assign quot_c = {dvd_q[WIDTH-2:0], step_q};

  // Next-state and next-output logic; cancel overrides everything, including start.
  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    lo_d       = lo_q;
    hi_d       = hi_q;
    cnt_d      = cnt_q;
    dvd_d      = dvd_q;
    rem_d      = rem_q;
    dvs_d      = dvs_q;
    quot_neg_d = quot_neg_q;
    rem_neg_d  = rem_neg_q;
    dbz_d      = dbz_q;

    if (cancel) begin
      state_d = ST_IDLE;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          busy_d = 1'b0;
          if (start) begin
            busy_d     = 1'b1;
            cnt_d      = '0;
            rem_d      = '0;
            dvs_d      = b_mag;
            quot_neg_d = a_neg ^ b_neg;
            rem_neg_d  = a_neg;
            dbz_d      = (operand_b == '0);
            if ((operand_b == '0) || early_c) begin
              // Short path keeps the raw dividend: it becomes the remainder as-is.
              state_d = ST_ZERO;
              dvd_d   = operand_a;
            end else begin
              state_d = ST_RUN;
              dvd_d   = a_mag;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_ZERO: begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          lo_d    = dbz_q ? {WIDTH{DIV_BY_ZERO_LO[0]}} : '0;
          hi_d    = dvd_q;
        end
        ST_RUN: begin
          rem_d = step_rem;
          dvd_d = quot_c;
          cnt_d = cnt_q + CNT_WIDTH'(1);
          if (cnt_d == CNT_WIDTH'(WIDTH)) begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            lo_d    = quot_neg_q ? (~quot_c + WIDTH'(1)) : quot_c;
            hi_d    = rem_neg_q ? (~step_rem + WIDTH'(1)) : step_rem;
          end
        end
        default: begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      lo_q       <= '0;
      hi_q       <= '0;
      cnt_q      <= '0;
      dvd_q      <= '0;
      rem_q      <= '0;
      dvs_q      <= '0;
      quot_neg_q <= 1'b0;
      rem_neg_q  <= 1'b0;
      dbz_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      lo_q       <= lo_d;
      hi_q       <= hi_d;
      cnt_q      <= cnt_d;
      dvd_q      <= dvd_d;
      rem_q      <= rem_d;
      dvs_q      <= dvs_d;
      quot_neg_q <= quot_neg_d;
      rem_neg_q  <= rem_neg_d;
      dbz_q      <= dbz_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result_lo = lo_q;
  assign result_hi = hi_q;

endmodule
